// File: rtl/display_scheduler_if.sv
// Handshake bundle between the display scheduler, its two requesters and display_out.
// The master side covers everything around the scheduler; the scheduler itself uses the slave side.
interface display_scheduler_if;
  logic        key_valid;
  logic [15:0] key_bcd;
  logic        key_ack;
  logic        res_valid;
  logic [15:0] res_bcd;
  logic        res_ack;
  logic        disp_enable;
  logic [15:0] disp_bcd;
  logic        disp_sending;
  logic        busy;
  logic        last_src;
  logic        timeout_err;

  modport master (
    output key_valid, key_bcd, res_valid, res_bcd, disp_sending,
    input  key_ack, res_ack, disp_enable, disp_bcd, busy, last_src, timeout_err
  );

  modport slave (
    input  key_valid, key_bcd, res_valid, res_bcd, disp_sending,
    output key_ack, res_ack, disp_enable, disp_bcd, busy, last_src, timeout_err
  );
endinterface

// File: rtl/display_scheduler.sv
// Shares the serial display driver between keypad echo (KEY) and ALU result (RES),
// one latched BCD word per frame, with periodic idle refresh and a start timeout.
module display_scheduler #(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned START_TIMEOUT  = 64,
  parameter logic [15:0] BLANK_WORD     = 16'hFFFF
) (
  input logic                clk,
  input logic                rst,
  display_scheduler_if.slave bus
);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  state_t        state;
  logic [RW-1:0] refresh_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [15:0]   disp_bcd_q;
  logic          disp_enable_q;
  logic          key_ack_q;
  logic          res_ack_q;
  logic          busy_q;
  logic          last_src_q;
  logic          timeout_err_q;
  logic          grant_res;

  // With both sources pending, the one not served last wins.
  assign grant_res = (bus.key_valid && bus.res_valid) ? ~last_src_q : bus.res_valid;

  // NOTE: all state and outputs are written with non-blocking assignments in a
  // single clocked block, so every output is a register and no latch can appear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      refresh_cnt   <= '0;
      timeout_cnt   <= '0;
      disp_bcd_q    <= BLANK_WORD;
      disp_enable_q <= 1'b0;
      key_ack_q     <= 1'b0;
      res_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      last_src_q    <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      key_ack_q <= 1'b0;
      res_ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.key_valid || bus.res_valid) begin
            disp_bcd_q    <= grant_res ? bus.res_bcd : bus.key_bcd;
            key_ack_q     <= ~grant_res;
            res_ack_q     <= grant_res;
            last_src_q    <= grant_res;
            refresh_cnt   <= '0;
            timeout_cnt   <= '0;
            disp_enable_q <= 1'b1;
            busy_q        <= 1'b1;
            state         <= START;
          end else if (REFRESH_CYCLES != 0 && refresh_cnt == REFRESH_LAST) begin
            // Resend the word already on disp_bcd; no requester is acknowledged.
            refresh_cnt   <= '0;
            timeout_cnt   <= '0;
            disp_enable_q <= 1'b1;
            busy_q        <= 1'b1;
            state         <= START;
          end else if (REFRESH_CYCLES != 0) begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        START: begin
          if (bus.disp_sending) begin
            disp_enable_q <= 1'b0;
            timeout_cnt   <= '0;
            state         <= SEND;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_err_q <= 1'b1;
            disp_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            timeout_cnt   <= '0;
            refresh_cnt   <= '0;
            state         <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        SEND: begin
          if (!bus.disp_sending) begin
            busy_q      <= 1'b0;
            refresh_cnt <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_bcd    = disp_bcd_q;
  assign bus.disp_enable = disp_enable_q;
  assign bus.key_ack     = key_ack_q;
  assign bus.res_ack     = res_ack_q;
  assign bus.busy        = busy_q;
  assign bus.last_src    = last_src_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios, then randomized
// requesters and a randomized display_out stub, all compared against a frame-level model.
module tb_display_scheduler;
  localparam int unsigned REFRESH = 50;
  localparam int unsigned TIMEOUT = 64;
  localparam logic [15:0] BLANK   = 16'hFFFF;

  localparam int W_IDLE = 0, W_BUSY = 1, W_KACK = 2, W_RACK = 3, W_SEND = 4, W_SENDING = 5, W_DRAIN = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  display_scheduler_if bus();

  display_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .START_TIMEOUT (TIMEOUT),
    .BLANK_WORD    (BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Stimulus controls
  bit hold_valids = 1'b0;
  bit rand_mode   = 1'b0;
  bit stub_rand   = 1'b0;
  bit stub_dead   = 1'b0;
  int fixed_delay = 1;
  int fixed_hold  = 2;
  int stub_st     = 0;
  int stub_cnt    = 0;
  int key_acks    = 0;
  int res_acks    = 0;
  bit grants[$];

  // Frame-level reference model: outputs expected after each rising edge.
  logic [15:0] m_bcd  = BLANK;
  bit          m_en   = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_kack = 1'b0;
  bit          m_rack = 1'b0;
  bit          m_last = 1'b1;
  bit          m_err  = 1'b0;
  int          m_idle = 0;
  int          m_wait = 0;
  bit          pick_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bcd = BLANK; m_en = 0; m_busy = 0; m_kack = 0; m_rack = 0;
      m_last = 1; m_err = 0; m_idle = 0; m_wait = 0;
    end else begin
      m_kack = 0;
      m_rack = 0;
      if (!m_busy) begin
        if (bus.key_valid || bus.res_valid) begin
          pick_res = (bus.key_valid && bus.res_valid) ? !m_last : bus.res_valid;
          m_bcd  = pick_res ? bus.res_bcd : bus.key_bcd;
          m_last = pick_res;
          m_kack = !pick_res;
          m_rack = pick_res;
          m_en = 1; m_busy = 1; m_wait = 0; m_idle = 0;
        end else if (REFRESH != 0 && m_idle == int'(REFRESH) - 1) begin
          m_en = 1; m_busy = 1; m_wait = 0; m_idle = 0;
        end else begin
          m_idle++;
        end
      end else if (m_en) begin
        if (bus.disp_sending) m_en = 0;
        else if (m_wait == int'(TIMEOUT) - 1) begin
          m_err = 1; m_en = 0; m_busy = 0; m_idle = 0;
        end else m_wait++;
      end else if (!bus.disp_sending) begin
        m_busy = 0;
        m_idle = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("busy",        bus.busy,        m_busy);
      check("disp_enable", bus.disp_enable, m_en);
      check("disp_bcd",    bus.disp_bcd,    m_bcd);
      check("key_ack",     bus.key_ack,     m_kack);
      check("res_ack",     bus.res_ack,     m_rack);
      check("last_src",    bus.last_src,    m_last);
      check("timeout_err", bus.timeout_err, m_err);
    end
  end

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  // One clock: requesters react to acks, optional random traffic, display_out stub.
  task automatic step();
    int d, h;
    @(posedge clk);
    #1;
    if (bus.key_ack) begin
      grants.push_back(1'b0);
      key_acks++;
      if (hold_valids) bus.key_bcd = rand_bcd();
      else bus.key_valid = 1'b0;
    end
    if (bus.res_ack) begin
      grants.push_back(1'b1);
      res_acks++;
      if (hold_valids) bus.res_bcd = rand_bcd();
      else bus.res_valid = 1'b0;
    end
    if (rand_mode) begin
      if (!bus.key_valid) begin
        if ($urandom_range(0, 3) == 0) begin bus.key_bcd = rand_bcd(); bus.key_valid = 1'b1; end
      end else if ($urandom_range(0, 7) == 0) bus.key_bcd = rand_bcd();
      if (!bus.res_valid) begin
        if ($urandom_range(0, 4) == 0) begin bus.res_bcd = rand_bcd(); bus.res_valid = 1'b1; end
      end else if ($urandom_range(0, 7) == 0) bus.res_bcd = rand_bcd();
    end
    d = stub_rand ? int'($urandom_range(0, 3)) : fixed_delay;
    h = stub_rand ? int'($urandom_range(1, 4)) : fixed_hold;
    if (!rst) begin
      stub_st = 0;
      bus.disp_sending = 1'b0;
    end else if (stub_st == 2) begin
      if (stub_cnt <= 1) begin bus.disp_sending = 1'b0; stub_st = 0; end
      else stub_cnt--;
    end else if (stub_st == 1) begin
      if (stub_cnt == 0) begin bus.disp_sending = 1'b1; stub_cnt = h; stub_st = 2; end
      else stub_cnt--;
    end else if (bus.disp_enable && !stub_dead) begin
      if (d == 0) begin bus.disp_sending = 1'b1; stub_cnt = h; stub_st = 2; end
      else begin stub_cnt = d; stub_st = 1; end
    end
  endtask

  function automatic bit cond(input int what);
    case (what)
      W_IDLE:    return !bus.busy;
      W_BUSY:    return bus.busy;
      W_KACK:    return bus.key_ack;
      W_RACK:    return bus.res_ack;
      W_SEND:    return bus.disp_sending && bus.busy && !bus.disp_enable;
      W_SENDING: return bus.disp_sending;
      default:   return !bus.key_valid && !bus.res_valid;
    endcase
  endfunction

  task automatic wait_until(input int what, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      step();
      hit = cond(what);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait %s: condition not reached within 500 clocks at %0t", name, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.res_valid = 1'b0;
    bus.disp_sending = 1'b0;
    stub_st = 0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int ka, ra, gap, n;
    logic [15:0] pre;
    bus.key_valid = 1'b0; bus.key_bcd = '0;
    bus.res_valid = 1'b0; bus.res_bcd = '0;
    bus.disp_sending = 1'b0;
    repeat (3) step();
    cmp_on = 1'b1;

    // Reset values
    check("rst disp_bcd", bus.disp_bcd, 16'hFFFF);
    check("rst disp_enable", bus.disp_enable, 0);
    check("rst busy", bus.busy, 0);
    check("rst last_src", bus.last_src, 1);
    check("rst timeout_err", bus.timeout_err, 0);
    check("rst acks", {bus.key_ack, bus.res_ack}, 0);
    rst = 1'b1;
    step();

    // Single KEY request
    fixed_delay = 2; fixed_hold = 3;
    bus.key_bcd = 16'h2571; bus.key_valid = 1'b1;
    step();
    check("t1 key_ack", bus.key_ack, 1);
    check("t1 disp_bcd", bus.disp_bcd, 16'h2571);
    check("t1 disp_enable", bus.disp_enable, 1);
    check("t1 last_src", bus.last_src, 0);
    check("t1 busy", bus.busy, 1);
    step();
    check("t1 key_ack width", bus.key_ack, 0);
    wait_until(W_SENDING, "t1 sending");
    check("t1 enable held", bus.disp_enable, 1);
    step();
    check("t1 enable dropped", bus.disp_enable, 0);
    wait_until(W_IDLE, "t1 idle");
    check("t1 ack count", key_acks, 1);

    // Simultaneous requests after reset: KEY first, then RES
    do_reset();
    bus.key_bcd = 16'h1234; bus.key_valid = 1'b1;
    bus.res_bcd = 16'h0042; bus.res_valid = 1'b1;
    step();
    check("t2 key first", {bus.key_ack, bus.res_ack}, 2'b10);
    check("t2 disp_bcd key", bus.disp_bcd, 16'h1234);
    ka = key_acks;
    wait_until(W_RACK, "t2 res ack");
    check("t2 disp_bcd res", bus.disp_bcd, 16'h0042);
    check("t2 last_src", bus.last_src, 1);
    check("t2 no extra key ack", key_acks - ka, 0);
    wait_until(W_IDLE, "t2 idle");

    // Both held for four frames: K,R,K,R
    grants.delete();
    ka = key_acks; ra = res_acks;
    hold_valids = 1'b1;
    bus.key_bcd = rand_bcd(); bus.key_valid = 1'b1;
    bus.res_bcd = rand_bcd(); bus.res_valid = 1'b1;
    for (int i = 0; i < 400 && grants.size() < 4; i++) step();
    check("t3 grant order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
    check("t3 ack counts", {16'(key_acks - ka), 16'(res_acks - ra)}, {16'd2, 16'd2});
    hold_valids = 1'b0;
    wait_until(W_DRAIN, "t3 drain");
    wait_until(W_IDLE, "t3 idle");

    // Idle refresh every REFRESH idle clocks, same word, no acks
    fixed_delay = 1; fixed_hold = 2;
    pre = bus.disp_bcd;
    ka = key_acks; ra = res_acks;
    for (int r = 0; r < 3; r++) begin
      wait_until(W_BUSY, "t4 busy");
      wait_until(W_IDLE, "t4 idle");
      gap = 1;
      while (!bus.disp_enable && gap < 300) begin
        step();
        if (!bus.disp_enable) gap++;
      end
      check("t4 idle gap", gap, REFRESH);
      check("t4 same word", bus.disp_bcd, pre);
    end
    check("t4 no acks", {16'(key_acks - ka), 16'(res_acks - ra)}, 0);
    wait_until(W_IDLE, "t4 end idle");

    // Start timeout, then a later request is still served
    check("t5 err before", bus.timeout_err, 0);
    stub_dead = 1'b1;
    bus.key_bcd = 16'h0314; bus.key_valid = 1'b1;
    step();
    check("t5 key_ack", bus.key_ack, 1);
    n = 1;
    while (bus.disp_enable && n < 300) begin
      step();
      if (bus.disp_enable) n++;
    end
    check("t5 enable clocks", n, TIMEOUT);
    check("t5 timeout_err", bus.timeout_err, 1);
    check("t5 back to idle", bus.busy, 0);
    stub_dead = 1'b0;
    bus.res_bcd = 16'h0789; bus.res_valid = 1'b1;
    wait_until(W_RACK, "t5 res ack");
    check("t5 served word", bus.disp_bcd, 16'h0789);
    check("t5 err sticky", bus.timeout_err, 1);
    wait_until(W_IDLE, "t5 idle");

    // Reset in the middle of SEND
    fixed_delay = 0; fixed_hold = 10;
    bus.key_bcd = 16'h5555; bus.key_valid = 1'b1;
    wait_until(W_SEND, "t6 send");
    step();
    #2;
    rst = 1'b0;
    bus.disp_sending = 1'b0;
    stub_st = 0;
    #1;
    check("t6 busy", bus.busy, 0);
    check("t6 disp_enable", bus.disp_enable, 0);
    check("t6 disp_bcd", bus.disp_bcd, 16'hFFFF);
    check("t6 last_src", bus.last_src, 1);
    check("t6 timeout_err", bus.timeout_err, 0);
    repeat (2) step();
    rst = 1'b1;
    fixed_delay = 1; fixed_hold = 2;
    bus.key_bcd = 16'h9876; bus.key_valid = 1'b1;
    wait_until(W_KACK, "t6 resume");
    check("t6 resume word", bus.disp_bcd, 16'h9876);
    check("t6 resume last_src", bus.last_src, 0);
    wait_until(W_IDLE, "t6 idle");

    // Randomized traffic against the model
    rand_mode = 1'b1;
    stub_rand = 1'b1;
    repeat (300) step();
    stub_dead = 1'b1;
    repeat (80) step();
    stub_dead = 1'b0;
    repeat (300) step();
    rand_mode = 1'b0;
    wait_until(W_DRAIN, "random drain");
    wait_until(W_IDLE, "random idle");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
